// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic MAC row.
// sat_add is only referenced when SYSTOLIC_ACC_SAT_EN is defined.
package systolic_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DRAIN
    } state_t;

    localparam int N_COLS_DEF  = 4;
    localparam int DRAIN_CNT_W = $clog2(N_COLS_DEF + 1);

    // Signed add clamped to the range of a w-bit two's-complement value (w <= 62).
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] x,
                                                   input logic signed [63:0] y,
                                                   input int                 w);
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = x + y;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (s > hi)
            return hi;
        else if (s < lo)
            return lo;
        else
            return s;
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// One processing element: a/valid/first pipeline stage, signed MAC and drain shift.
// Define SYSTOLIC_ACC_SAT_EN for saturating accumulation; otherwise the sum wraps.
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] a_prev,
    input  logic                     v_prev,
    input  logic                     f_prev,
    input  logic signed [DATA_W-1:0] b,
    input  logic                     shift,
    input  logic signed [ACC_W-1:0]  acc_prev,
    output logic signed [DATA_W-1:0] a,
    output logic                     v,
    output logic                     f,
    output logic signed [ACC_W-1:0]  acc
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    base;
    logic signed [ACC_W-1:0]    acc_sum;

    always_comb begin
        prod     = a * b;
        prod_ext = ACC_W'(prod);
        base     = f ? '0 : acc;
`ifdef SYSTOLIC_ACC_SAT_EN
        acc_sum  = ACC_W'(sat_add(64'(base), 64'(prod_ext), ACC_W));
`else
        acc_sum  = base + prod_ext;
`endif
    end

    // NOTE: every register here, including acc, is cleared by reset; a drain
    // aborted by reset must not leave stale partial sums behind.
    always_ff @(posedge clock) begin
        if (reset) begin
            a   <= '0;
            v   <= 1'b0;
            f   <= 1'b0;
            acc <= '0;
        end else begin
            a <= a_prev;
            v <= v_prev;
            f <= f_prev;
            if (shift)
                acc <= acc_prev;
            else if (v)
                acc <= acc_sum;
        end
    end

endmodule

// File: rtl/systolic_row.sv
// Row of N_COLS chained PEs with drain sequencer (IDLE -> WAIT -> DRAIN).
// SYSTOLIC_ACC_SAT_EN selects saturating accumulators inside systolic_pe.
module systolic_row
    import systolic_pkg::*;
#(
    parameter int N_COLS = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          a_in,
    input  logic                       first,
    input  logic [N_COLS*DATA_W-1:0]   b_in,
    input  logic                       drain_start,
    output logic [DATA_W-1:0]          a_out,
    output logic                       a_valid_out,
    output logic                       drain_valid,
    output logic [ACC_W-1:0]           drain_data,
    output logic                       busy,
    output logic                       drop_err
);

    localparam int CNT_W = $clog2(N_COLS + 1);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic               shift;
    logic [N_COLS-1:0]  pe_valid;

    logic signed [DATA_W-1:0] a_chain   [N_COLS+1];
    logic                     v_chain   [N_COLS+1];
    logic                     f_chain   [N_COLS+1];
    logic signed [ACC_W-1:0]  acc_chain [N_COLS+1];
    logic                     unused_f_last;

    assign busy          = (state != S_IDLE);
    assign shift         = (state == S_DRAIN);
    assign accept        = in_valid & ~busy;
    assign a_chain[0]    = a_in;
    assign v_chain[0]    = accept;
    assign f_chain[0]    = first & accept;
    assign acc_chain[0]  = '0;
    assign unused_f_last = f_chain[N_COLS];

    for (genvar i = 0; i < N_COLS; i++) begin : g_pe
        systolic_pe #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W)
        ) u_pe (
            .clock    (clock),
            .reset    (reset),
            .a_prev   (a_chain[i]),
            .v_prev   (v_chain[i]),
            .f_prev   (f_chain[i]),
            .b        (b_in[i*DATA_W +: DATA_W]),
            .shift    (shift),
            .acc_prev (acc_chain[i]),
            .a        (a_chain[i+1]),
            .v        (v_chain[i+1]),
            .f        (f_chain[i+1]),
            .acc      (acc_chain[i+1])
        );
        assign pe_valid[i] = v_chain[i+1];
    end

    assign a_out       = a_chain[N_COLS];
    assign a_valid_out = v_chain[N_COLS];
    assign drain_valid = shift;
    assign drain_data  = shift ? acc_chain[N_COLS] : '0;

    // WAIT holds until the last in-flight beat has landed in every accumulator.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (drain_start)                 state_next = S_WAIT;
            S_WAIT:  if (pe_valid == '0)              state_next = S_DRAIN;
            S_DRAIN: if (cnt == CNT_W'(N_COLS - 1))   state_next = S_IDLE;
            default:                                  state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            drop_err <= 1'b0;
        end else begin
            state <= state_next;
            if (shift)
                cnt <= cnt + CNT_W'(1);
            else
                cnt <= '0;
            if (in_valid && busy)
                drop_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_systolic_row.sv
// Directed bench for systolic_row: table-driven MAC/drain vectors plus hand-written
// corner sequences (WAIT timing, dropped beats, reset mid-drain, 16-bit accumulator).
module tb_systolic_row;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int AW  = 20;
    localparam int AW2 = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic                 in_valid = 1'b0;
    logic [DW-1:0]        a_in = '0;
    logic                 first = 1'b0;
    logic [N*DW-1:0]      b_in = '0;
    logic                 drain_start = 1'b0;
    logic [DW-1:0]        a_out;
    logic                 a_valid_out;
    logic                 drain_valid;
    logic [AW-1:0]        drain_data;
    logic                 busy;
    logic                 drop_err;

    logic                 s_in_valid = 1'b0;
    logic [DW-1:0]        s_a_in = '0;
    logic                 s_first = 1'b0;
    logic [N*DW-1:0]      s_b_in = '0;
    logic                 s_drain_start = 1'b0;
    logic [DW-1:0]        s_a_out;
    logic                 s_a_valid_out;
    logic                 s_drain_valid;
    logic [AW2-1:0]       s_drain_data;
    logic                 s_busy;
    logic                 s_drop_err;

    systolic_row #(.N_COLS(N), .DATA_W(DW), .ACC_W(AW)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .a_in(a_in), .first(first),
        .b_in(b_in), .drain_start(drain_start), .a_out(a_out), .a_valid_out(a_valid_out),
        .drain_valid(drain_valid), .drain_data(drain_data), .busy(busy), .drop_err(drop_err)
    );

    systolic_row #(.N_COLS(N), .DATA_W(DW), .ACC_W(AW2)) dut16 (
        .clock(clock), .reset(reset), .in_valid(s_in_valid), .a_in(s_a_in), .first(s_first),
        .b_in(s_b_in), .drain_start(s_drain_start), .a_out(s_a_out), .a_valid_out(s_a_valid_out),
        .drain_valid(s_drain_valid), .drain_data(s_drain_data), .busy(s_busy), .drop_err(s_drop_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef int exp4_t [N];

    typedef struct {
        logic signed [DW-1:0] a;
        logic signed [DW-1:0] b [N];
        int                   beats;
        exp4_t                exp;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_b(input logic signed [DW-1:0] b [N]);
        for (int i = 0; i < N; i++) b_in[i*DW +: DW] = b[i];
    endtask

    task automatic beats(input logic signed [DW-1:0] a, input int count);
        for (int k = 0; k < count; k++) begin
            in_valid = 1'b1;
            a_in     = a;
            first    = (k == 0);
            step();
        end
        in_valid = 1'b0;
        first    = 1'b0;
    endtask

    task automatic wait_drain();
        int w = 0;
        while (!drain_valid && w < 32) begin
            step();
            w++;
        end
    endtask

    // Drained order is PE N-1 first, so drain cycle k carries exp[N-1-k].
    task automatic run_drain(input string tag, input exp4_t exp);
        drain_start = 1'b1;
        step();
        drain_start = 1'b0;
        check({tag, " busy_after_start"}, busy, 1);
        wait_drain();
        for (int k = 0; k < N; k++) begin
            check($sformatf("%s dv[%0d]", tag, k), drain_valid, 1);
            check($sformatf("%s data[%0d]", tag, k), $signed(drain_data), exp[N-1-k]);
            step();
        end
        check({tag, " dv_end"}, drain_valid, 0);
        check({tag, " busy_end"}, busy, 0);
    endtask

    initial begin
        exp4_t zeros = '{0, 0, 0, 0};
        exp4_t e;
        logic signed [DW-1:0] ones [N] = '{8'sd1, 8'sd1, 8'sd1, 8'sd1};
        int w;

        vecs[0] = '{a: 8'sd3,    b: '{8'sd2, 8'sd2, 8'sd2, 8'sd2},         beats: 5, exp: '{30, 30, 30, 30}};
        vecs[1] = '{a: -8'sd128, b: '{-8'sd128, -8'sd128, -8'sd128, -8'sd128}, beats: 1, exp: '{16384, 16384, 16384, 16384}};
        vecs[2] = '{a: 8'sd5,    b: '{-8'sd7, -8'sd7, -8'sd7, -8'sd7},     beats: 1, exp: '{-35, -35, -35, -35}};
        vecs[3] = '{a: 8'sd7,    b: '{8'sd1, -8'sd2, 8'sd3, -8'sd4},       beats: 3, exp: '{21, -42, 63, -84}};
        vecs[4] = '{a: 8'sd127,  b: '{-8'sd128, -8'sd128, -8'sd128, -8'sd128}, beats: 4, exp: '{-65024, -65024, -65024, -65024}};

        step();
        step();
        reset = 1'b0;
        check("rst a_out", a_out, 0);
        check("rst a_valid_out", a_valid_out, 0);
        check("rst drain_valid", drain_valid, 0);
        check("rst drain_data", drain_data, 0);
        check("rst busy", busy, 0);
        check("rst drop_err", drop_err, 0);

        // Table: beats, then drain_start one cycle after the last beat.
        for (int v = 0; v < 5; v++) begin
            set_b(vecs[v].b);
            beats(vecs[v].a, vecs[v].beats);
            run_drain($sformatf("vec%0d", v), vecs[v].exp);
        end

        // a_out latency is N_COLS cycles from the accepting edge.
        set_b(ones);
        in_valid = 1'b1; a_in = 8'd53; first = 1'b1;
        step();
        in_valid = 1'b0; first = 1'b0;
        step();
        step();
        check("lat a_valid early", a_valid_out, 0);
        step();
        check("lat a_valid", a_valid_out, 1);
        check("lat a_out", a_out, 53);
        step();
        check("lat a_valid after", a_valid_out, 0);
        e = '{53, 53, 53, 53};
        run_drain("lat", e);

        // first without in_valid is ignored: 2*3 then +1*3.
        set_b('{8'sd3, 8'sd3, 8'sd3, 8'sd3});
        beats(8'sd2, 1);
        first = 1'b1;
        step();
        first = 1'b0;
        in_valid = 1'b1; a_in = 8'd1;
        step();
        in_valid = 1'b0;
        e = '{9, 9, 9, 9};
        run_drain("first_ign", e);

        // drain_start together with the last beat: that beat still counts.
        set_b(ones);
        in_valid = 1'b1; a_in = 8'd4; first = 1'b1;
        step();
        first = 1'b0; a_in = 8'd5; drain_start = 1'b1;
        step();
        in_valid = 1'b0; drain_start = 1'b0;
        check("same busy", busy, 1);
        check("same no dv yet", drain_valid, 0);
        wait_drain();
        for (int k = 0; k < N; k++) begin
            check($sformatf("same data[%0d]", k), $signed(drain_data), 9);
            step();
        end
        check("same busy_end", busy, 0);
        check("same drop_err", drop_err, 0);

        // Beat during DRAIN is dropped and latches drop_err.
        beats(8'sd10, 1);
        drain_start = 1'b1;
        step();
        drain_start = 1'b0;
        wait_drain();
        check("drop data0", $signed(drain_data), 10);
        in_valid = 1'b1; a_in = 8'd100; first = 1'b1;
        step();
        in_valid = 1'b0; first = 1'b0;
        check("drop err set", drop_err, 1);
        for (int k = 1; k < N; k++) begin
            check($sformatf("drop data[%0d]", k), $signed(drain_data), 10);
            step();
        end
        run_drain("drop redrain", zeros);
        check("drop err sticky", drop_err, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("drop err cleared", drop_err, 0);

        // Reset on the second DRAIN cycle aborts the drain.
        beats(8'sd6, 1);
        drain_start = 1'b1;
        step();
        drain_start = 1'b0;
        wait_drain();
        check("rstd data0", $signed(drain_data), 6);
        step();
        check("rstd dv1", drain_valid, 1);
        reset = 1'b1;
        step();
        check("rstd dv", drain_valid, 0);
        check("rstd busy", busy, 0);
        check("rstd data", drain_data, 0);
        reset = 1'b0;
        run_drain("rstd redrain", zeros);

        // 16-bit accumulator: 3 x (127*127) = 48387 overflows.
        for (int i = 0; i < N; i++) s_b_in[i*DW +: DW] = 8'sd127;
        s_in_valid = 1'b1; s_a_in = 8'sd127; s_first = 1'b1;
        step();
        s_first = 1'b0;
        step();
        step();
        s_in_valid = 1'b0; s_drain_start = 1'b1;
        step();
        s_drain_start = 1'b0;
        w = 0;
        while (!s_drain_valid && w < 32) begin
            step();
            w++;
        end
        for (int k = 0; k < N; k++) begin
            check($sformatf("acc16 dv[%0d]", k), s_drain_valid, 1);
`ifdef SYSTOLIC_ACC_SAT_EN
            check($sformatf("acc16 data[%0d]", k), $signed(s_drain_data), 32767);
`else
            check($sformatf("acc16 data[%0d]", k), $signed(s_drain_data), -17149);
`endif
            step();
        end
        check("acc16 busy_end", s_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
